// File: rtl/pipe_ctrl_pkg.sv
// Shared types, constants and helpers for the pipeline hazard/forwarding controller.
// Scoreboard address fields are SB_AW wide, so REG_AW may be at most SB_AW.
package pipe_ctrl_pkg;

  localparam int SB_AW       = 8;
  localparam int FWD_REGFILE = 0;
  localparam int FLUSH_IFID  = 0;

  typedef struct packed {
    logic             valid;
    logic [SB_AW-1:0] dest;
    logic             wr_en;
    logic             is_load;
    logic [SB_AW-1:0] rs;
    logic [SB_AW-1:0] rt;
    logic             use_rs;
    logic             use_rt;
  } sb_entry_t;

  function automatic int fwd_width(input int stages);
    return $clog2(stages + 1);
  endfunction

endpackage

// File: rtl/pipe_sb_match.sv
// Compares one scoreboard entry against one source register address.
// o_match ignores register 0; o_isLoad marks a match whose producer is a load.
module pipe_sb_match
  import pipe_ctrl_pkg::*;
(
  input  logic             i_valid,
  input  logic             i_wrEn,
  input  logic             i_isLoad,
  input  logic [SB_AW-1:0] i_dest,
  input  logic [SB_AW-1:0] i_src,
  input  logic             i_use,
  output logic             o_match,
  output logic             o_isLoad
);

  assign o_match  = i_use && i_valid && i_wrEn && (i_dest == i_src) && (i_dest != '0);
  assign o_isLoad = o_match && i_isLoad;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Parametrised hazard/forwarding controller: scoreboard of post-ID stages driving
// forwarding selects, load-use stall, freeze and IF2ID flush. Optional counters: HAZ_STATS_EN.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter  int REG_AW   = 5,
  parameter  int STAGES   = 3,
  parameter  int LOAD_LAT = 1,
  localparam int FW       = fwd_width(STAGES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [REG_AW-1:0] id_dest,
  input  logic              id_wr_en,
  input  logic              id_is_load,
  input  logic              id_branch_taken,
  input  logic              id_jump,
  input  logic              ext_freeze,
  output logic [FW-1:0]     fwd_a,
  output logic [FW-1:0]     fwd_b,
  output logic              stall,
  output logic              freeze,
  output logic [1:0]        flush
`ifdef HAZ_STATS_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
`endif
);

  sb_entry_t         r_sb [1:STAGES];
  sb_entry_t         w_idEntry;
  logic [STAGES:2]   w_hitA, w_hitB, w_ldA, w_ldB;
  logic [LOAD_LAT:1] w_hazRs, w_hazRt, w_ldHazRs, w_ldHazRt;
  logic [FW-1:0]     w_selA, w_selB;
  logic              w_loadUse;
  logic              w_unused;

  always_comb begin
    w_idEntry         = '0;
    w_idEntry.valid   = id_valid;
    w_idEntry.dest    = SB_AW'(id_dest);
    w_idEntry.wr_en   = id_wr_en;
    w_idEntry.is_load = id_is_load;
    w_idEntry.rs      = SB_AW'(id_rs);
    w_idEntry.rt      = SB_AW'(id_rt);
    w_idEntry.use_rs  = id_use_rs;
    w_idEntry.use_rt  = id_use_rt;
  end

  // Forwarding compares the instruction now in EXE (entry 1) against older producers.
  for (genvar k = 2; k <= STAGES; k++) begin : g_fwd
    pipe_sb_match u_matchA (
      .i_valid (r_sb[k].valid),   .i_wrEn (r_sb[k].wr_en),  .i_isLoad (r_sb[k].is_load),
      .i_dest  (r_sb[k].dest),    .i_src  (r_sb[1].rs),     .i_use    (r_sb[1].use_rs),
      .o_match (w_hitA[k]),       .o_isLoad (w_ldA[k])
    );
    pipe_sb_match u_matchB (
      .i_valid (r_sb[k].valid),   .i_wrEn (r_sb[k].wr_en),  .i_isLoad (r_sb[k].is_load),
      .i_dest  (r_sb[k].dest),    .i_src  (r_sb[1].rt),     .i_use    (r_sb[1].use_rt),
      .o_match (w_hitB[k]),       .o_isLoad (w_ldB[k])
    );
  end

  // Load-use detection looks at the ID sources against loads whose data is not yet forwardable.
  for (genvar k = 1; k <= LOAD_LAT; k++) begin : g_haz
    pipe_sb_match u_hazRs (
      .i_valid (r_sb[k].valid),   .i_wrEn (r_sb[k].wr_en),  .i_isLoad (r_sb[k].is_load),
      .i_dest  (r_sb[k].dest),    .i_src  (w_idEntry.rs),   .i_use    (id_use_rs),
      .o_match (w_hazRs[k]),      .o_isLoad (w_ldHazRs[k])
    );
    pipe_sb_match u_hazRt (
      .i_valid (r_sb[k].valid),   .i_wrEn (r_sb[k].wr_en),  .i_isLoad (r_sb[k].is_load),
      .i_dest  (r_sb[k].dest),    .i_src  (w_idEntry.rt),   .i_use    (id_use_rt),
      .o_match (w_hazRt[k]),      .o_isLoad (w_ldHazRt[k])
    );
  end

  assign w_unused = ^{w_ldA, w_ldB, w_hazRs, w_hazRt};

  // Scan oldest to youngest so the youngest producer overrides.
  always_comb begin
    w_selA = FW'(FWD_REGFILE);
    w_selB = FW'(FWD_REGFILE);
    for (int k = STAGES; k >= 2; k--) begin
      if (w_hitA[k]) w_selA = FW'(k);
      if (w_hitB[k]) w_selB = FW'(k);
    end
  end

  assign w_loadUse = id_valid && ((|w_ldHazRs) || (|w_ldHazRt));

  assign fwd_a  = rst ? '0 : w_selA;
  assign fwd_b  = rst ? '0 : w_selB;
  assign stall  = !rst && w_loadUse;
  assign freeze = !rst && (w_loadUse || ext_freeze);

  always_comb begin
    flush             = '0;
    flush[FLUSH_IFID] = !rst && (id_branch_taken || id_jump) && !w_loadUse && !ext_freeze;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 1; k <= STAGES; k++) r_sb[k] <= '0;
    end else if (!ext_freeze) begin
      r_sb[1] <= w_loadUse ? '0 : w_idEntry;
      for (int k = 2; k <= STAGES; k++) r_sb[k] <= r_sb[k-1];
    end
  end

`ifdef HAZ_STATS_EN
  logic [31:0] r_stallCnt, r_flushCnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stallCnt <= '0;
      r_flushCnt <= '0;
    end else begin
      if (w_loadUse && !ext_freeze && (r_stallCnt != '1)) r_stallCnt <= r_stallCnt + 32'd1;
      if (flush[FLUSH_IFID] && (r_flushCnt != '1)) r_flushCnt <= r_flushCnt + 32'd1;
    end
  end

  assign stall_cnt = r_stallCnt;
  assign flush_cnt = r_flushCnt;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench: a 3/1 and a 5/2 instance share directed stimulus and are
// compared every cycle against a queue model of the in-flight instructions.
module tb_pipe_hazard_ctrl;

  typedef struct {
    bit v;
    int dest;
    bit wr;
    bit ld;
    int rs;
    int rt;
    bit urs;
    bit urt;
  } instr_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_use_rs, id_use_rt, id_wr_en, id_is_load;
  logic [4:0] id_rs, id_rt, id_dest;
  logic       id_branch_taken, id_jump, ext_freeze;

  logic [1:0] fwd_a3, fwd_b3, flush3;
  logic       stall3, freeze3;
  logic [2:0] fwd_a5, fwd_b5;
  logic [1:0] flush5;
  logic       stall5, freeze5;
`ifdef HAZ_STATS_EN
  logic [31:0] stallCnt3, flushCnt3, stallCnt5, flushCnt5;
`endif

  int checks = 0;
  int errors = 0;
  instr_t q3[$];
  instr_t q5[$];

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_AW(5), .STAGES(3), .LOAD_LAT(1)) dut3 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dest(id_dest), .id_wr_en(id_wr_en),
    .id_is_load(id_is_load), .id_branch_taken(id_branch_taken), .id_jump(id_jump),
    .ext_freeze(ext_freeze), .fwd_a(fwd_a3), .fwd_b(fwd_b3), .stall(stall3),
    .freeze(freeze3), .flush(flush3)
`ifdef HAZ_STATS_EN
    , .stall_cnt(stallCnt3), .flush_cnt(flushCnt3)
`endif
  );

  pipe_hazard_ctrl #(.REG_AW(5), .STAGES(5), .LOAD_LAT(2)) dut5 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dest(id_dest), .id_wr_en(id_wr_en),
    .id_is_load(id_is_load), .id_branch_taken(id_branch_taken), .id_jump(id_jump),
    .ext_freeze(ext_freeze), .fwd_a(fwd_a5), .fwd_b(fwd_b5), .stall(stall5),
    .freeze(freeze5), .flush(flush5)
`ifdef HAZ_STATS_EN
    , .stall_cnt(stallCnt5), .flush_cnt(flushCnt5)
`endif
  );

  function automatic instr_t nop();
    instr_t e;
    e = '{default: 0};
    return e;
  endfunction

  function automatic instr_t op(input int dest, input bit wr, input bit ld,
                                input int rs, input bit urs, input int rt, input bit urt);
    instr_t e;
    e.v = 1'b1; e.dest = dest; e.wr = wr; e.ld = ld;
    e.rs = rs; e.urs = urs; e.rt = rt; e.urt = urt;
    return e;
  endfunction

  function automatic instr_t curId();
    instr_t e;
    e.v = id_valid; e.dest = int'(id_dest); e.wr = id_wr_en; e.ld = id_is_load;
    e.rs = int'(id_rs); e.urs = id_use_rs; e.rt = int'(id_rt); e.urt = id_use_rt;
    return e;
  endfunction

  function automatic bit writes(input instr_t e, input int r);
    return e.v && e.wr && (e.dest == r) && (r != 0);
  endfunction

  // q[0] is the instruction in EXE (stage 1); q[k-1] is stage k.
  function automatic int expFwd(input instr_t q[$], input int stages, input bit isB);
    int src;
    bit u;
    if (q.size() == 0) return 0;
    src = isB ? q[0].rt : q[0].rs;
    u   = isB ? q[0].urt : q[0].urs;
    if (!u) return 0;
    for (int k = 2; k <= stages && k <= q.size(); k++)
      if (writes(q[k-1], src)) return k;
    return 0;
  endfunction

  function automatic bit expStall(input instr_t q[$], input int lat, input instr_t id);
    if (!id.v) return 1'b0;
    for (int k = 1; k <= lat && k <= q.size(); k++)
      if (q[k-1].ld && ((id.urs && writes(q[k-1], id.rs)) || (id.urt && writes(q[k-1], id.rt))))
        return 1'b1;
    return 1'b0;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input instr_t ins, input bit br, input bit jmp,
                               input bit frz, input bit r);
    @(posedge clk);
    #1;
    rst             = r;
    id_valid        = ins.v;
    id_dest         = ins.dest[4:0];
    id_wr_en        = ins.wr;
    id_is_load      = ins.ld;
    id_rs           = ins.rs[4:0];
    id_use_rs       = ins.urs;
    id_rt           = ins.rt[4:0];
    id_use_rt       = ins.urt;
    id_branch_taken = br;
    id_jump         = jmp;
    ext_freeze      = frz;
    @(negedge clk);
  endtask

  task automatic issue(input instr_t ins);
    applyStimulus(ins, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Model advance: on each edge the ID instruction (or a bubble on stall) enters stage 1.
  always @(posedge clk) begin : mdlUpdate
    instr_t id;
    id = curId();
    if (rst) begin
      q3.delete();
      q5.delete();
    end else if (!ext_freeze) begin
      q3.push_front(expStall(q3, 1, id) ? nop() : id);
      if (q3.size() > 3) void'(q3.pop_back());
      q5.push_front(expStall(q5, 2, id) ? nop() : id);
      if (q5.size() > 5) void'(q5.pop_back());
    end
  end

  always @(negedge clk) begin : mdlCompare
    instr_t id;
    bit s3, s5, br;
    id = curId();
    br = id_branch_taken || id_jump;
    s3 = !rst && expStall(q3, 1, id);
    s5 = !rst && expStall(q5, 2, id);
    checkOutput("dut3.fwd_a",  int'(fwd_a3),  rst ? 0 : expFwd(q3, 3, 1'b0));
    checkOutput("dut3.fwd_b",  int'(fwd_b3),  rst ? 0 : expFwd(q3, 3, 1'b1));
    checkOutput("dut3.stall",  int'(stall3),  int'(s3));
    checkOutput("dut3.freeze", int'(freeze3), int'(!rst && (s3 || ext_freeze)));
    checkOutput("dut3.flush",  int'(flush3),  int'(!rst && br && !s3 && !ext_freeze));
    checkOutput("dut5.fwd_a",  int'(fwd_a5),  rst ? 0 : expFwd(q5, 5, 1'b0));
    checkOutput("dut5.fwd_b",  int'(fwd_b5),  rst ? 0 : expFwd(q5, 5, 1'b1));
    checkOutput("dut5.stall",  int'(stall5),  int'(s5));
    checkOutput("dut5.freeze", int'(freeze5), int'(!rst && (s5 || ext_freeze)));
    checkOutput("dut5.flush",  int'(flush5),  int'(!rst && br && !s5 && !ext_freeze));
  end

  initial begin
    rst = 1'b1;
    id_valid = 1'b0; id_dest = '0; id_wr_en = 1'b0; id_is_load = 1'b0;
    id_rs = '0; id_use_rs = 1'b0; id_rt = '0; id_use_rt = 1'b0;
    id_branch_taken = 1'b0; id_jump = 1'b0; ext_freeze = 1'b0;

    // Reset: a jump during reset must not flush.
    applyStimulus(op(0, 0, 0, 0, 0, 0, 0), 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("reset flush", int'(flush3), 0);
    checkOutput("reset freeze", int'(freeze3), 0);
    checkOutput("reset fwd_a", int'(fwd_a3), 0);
    applyStimulus(nop(), 1'b0, 1'b0, 1'b0, 1'b1);
    issue(nop());
    issue(nop());

    // ALU chain: add r3,r1,r2 ; sub r4,r3,r5
    issue(op(3, 1, 0, 1, 1, 2, 1));
    issue(op(4, 1, 0, 3, 1, 5, 1));
    checkOutput("alu stall", int'(stall3), 0);
    issue(nop());
    checkOutput("alu fwd_a", int'(fwd_a3), 2);
    checkOutput("alu fwd_b", int'(fwd_b3), 0);
    issue(nop());
    issue(nop());

    // Load-use: lw r6,0(r1) ; add r7,r6,r6
    issue(op(6, 1, 1, 1, 1, 0, 0));
    issue(op(7, 1, 0, 6, 1, 6, 1));
    checkOutput("lu stall", int'(stall3), 1);
    checkOutput("lu freeze", int'(freeze3), 1);
    issue(op(7, 1, 0, 6, 1, 6, 1));
    checkOutput("lu stall end", int'(stall3), 0);
    checkOutput("lu freeze end", int'(freeze3), 0);
    issue(nop());
    checkOutput("lu fwd_a", int'(fwd_a3), 3);
    checkOutput("lu fwd_b", int'(fwd_b3), 3);

    // Register 0 never matches, even for a load.
    issue(op(0, 1, 1, 1, 1, 0, 0));
    issue(op(8, 1, 0, 0, 1, 0, 1));
    checkOutput("r0 stall", int'(stall3), 0);
    issue(nop());
    checkOutput("r0 fwd_a", int'(fwd_a3), 0);
    checkOutput("r0 fwd_b", int'(fwd_b3), 0);

    // Youngest producer wins.
    issue(op(3, 1, 0, 1, 1, 2, 1));
    issue(op(3, 1, 0, 1, 1, 2, 1));
    issue(op(9, 1, 0, 3, 1, 0, 0));
    issue(nop());
    checkOutput("young fwd_a", int'(fwd_a3), 2);

    // Jump with no hazard.
    applyStimulus(op(0, 0, 0, 0, 0, 0, 0), 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("jump flush", int'(flush3), 1);
    issue(nop());
    checkOutput("jump flush end", int'(flush3), 0);

    // Taken branch during a load-use stall is deferred one cycle.
    issue(op(10, 1, 1, 1, 1, 0, 0));
    applyStimulus(op(0, 0, 0, 10, 1, 0, 0), 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("br stall", int'(stall3), 1);
    checkOutput("br flush held", int'(flush3), 0);
    applyStimulus(op(0, 0, 0, 10, 1, 0, 0), 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("br flush", int'(flush3), 1);
    issue(nop());

    // External freeze during load-use: no bubble until the freeze lifts.
    issue(op(11, 1, 1, 1, 1, 0, 0));
    for (int i = 0; i < 3; i++) begin
      applyStimulus(op(12, 1, 0, 11, 1, 0, 0), 1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("frz stall", int'(stall3), 1);
      checkOutput("frz freeze", int'(freeze3), 1);
    end
    issue(op(12, 1, 0, 11, 1, 0, 0));
    checkOutput("frz stall after", int'(stall3), 1);
    issue(op(12, 1, 0, 11, 1, 0, 0));
    checkOutput("frz stall done", int'(stall3), 0);
    issue(nop());

    // Reset while a stall is pending behind a freeze.
    issue(op(13, 1, 1, 1, 1, 0, 0));
    applyStimulus(op(14, 1, 0, 13, 1, 0, 0), 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("rst pre stall", int'(stall3), 1);
    applyStimulus(op(14, 1, 0, 13, 1, 0, 0), 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("rst stall", int'(stall3), 0);
    checkOutput("rst freeze", int'(freeze3), 0);
    issue(op(14, 1, 0, 13, 1, 0, 0));
    checkOutput("rst cleared stall", int'(stall3), 0);
    issue(nop());
    checkOutput("rst cleared fwd_a", int'(fwd_a3), 0);

    // STAGES=5, LOAD_LAT=2: use two instructions after a load stalls once.
    for (int i = 0; i < 5; i++) issue(nop());
    issue(op(15, 1, 1, 1, 1, 0, 0));
    issue(op(16, 1, 0, 1, 1, 2, 1));
    checkOutput("s5 indep stall", int'(stall5), 0);
    issue(op(17, 1, 0, 15, 1, 0, 0));
    checkOutput("s5 stall", int'(stall5), 1);
    checkOutput("s5 freeze", int'(freeze5), 1);
    issue(op(17, 1, 0, 15, 1, 0, 0));
    checkOutput("s5 stall end", int'(stall5), 0);
    issue(nop());
    checkOutput("s5 fwd_a", int'(fwd_a5), 4);
    for (int i = 0; i < 3; i++) issue(nop());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
